// File: rtl/game_status_controller.sv
// Game status controller.
// Turn sequencer that sits between the move validator / win detector and the
// 8-bit game status register. It decides, once per clock, whether a status
// write is due and which code to write, and keeps the per-turn bookkeeping
// (player to move, turn countdown, legal-move count, result) for the display.
//
// Every output comes straight from a flop. The next-state logic computes the
// complete next value of every register, so an input sampled at one edge is
// visible on the outputs right after that edge. status_we is a one-cycle
// pulse, and status_next only moves in the cycle where that pulse is high.

module game_status_controller #(
    parameter int TURN_TIME = 10,   // turn length in tick pulses (1..15)
    parameter int ERR_HOLD  = 2,    // ticks the invalid-move status is held (1..15)
    parameter int MAX_MOVES = 42    // cell count; reaching it without a win is a draw (1..63)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    input  logic       move_invalid,
    input  logic       win_detect,
    input  logic       board_full,
    input  logic       tick,
    output logic       status_we,
    output logic [7:0] status_next,
    output logic       current_player,
    output logic [3:0] turn_timer,
    output logic [5:0] move_count,
    output logic       game_over,
    output logic [1:0] winner
);

    // Status codes written to the status register.
    localparam logic [7:0] CODE_PLAYING = 8'h00;
    localparam logic [7:0] CODE_INVALID = 8'h01;
    localparam logic [7:0] CODE_TIMEOUT = 8'h02;
    localparam logic [7:0] CODE_WIN_P0  = 8'h10;
    localparam logic [7:0] CODE_DRAW    = 8'h20;

    // Parameters narrowed to the widths of the registers they load or compare.
    localparam logic [3:0] TURN_TIME_C = 4'(TURN_TIME);
    localparam logic [3:0] ERR_HOLD_C  = 4'(ERR_HOLD);
    localparam logic [5:0] MAX_MOVES_C = 6'(MAX_MOVES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        ERROR = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Win code for the player that just moved: 0x10 for player 0, 0x11 for player 1.
    function automatic logic [7:0] win_code(input logic player);
        win_code = CODE_WIN_P0 | {7'd0, player};
    endfunction

    // Winner encoding for the player that just moved: 1 for player 0, 2 for player 1.
    function automatic logic [1:0] winner_code(input logic player);
        winner_code = {1'b0, player} + 2'd1;
    endfunction

    // Registered state.
    state_t     state_r;
    logic [3:0] err_cnt_r;
    logic       status_we_r;
    logic [7:0] status_next_r;
    logic       current_player_r;
    logic [3:0] turn_timer_r;
    logic [5:0] move_count_r;
    logic       game_over_r;
    logic [1:0] winner_r;

    // Next-state values.
    state_t     state_s;
    logic [3:0] err_cnt_s;
    logic       status_we_s;
    logic [7:0] status_next_s;
    logic       current_player_s;
    logic [3:0] turn_timer_s;
    logic [5:0] move_count_s;
    logic       game_over_s;
    logic [1:0] winner_s;
    logic [5:0] move_inc_s;

    // State and output registers; reset clears everything, including the error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            err_cnt_r        <= 4'd0;
            status_we_r      <= 1'b0;
            status_next_r    <= CODE_PLAYING;
            current_player_r <= 1'b0;
            turn_timer_r     <= 4'd0;
            move_count_r     <= 6'd0;
            game_over_r      <= 1'b0;
            winner_r         <= 2'd0;
        end else begin
            state_r          <= state_s;
            err_cnt_r        <= err_cnt_s;
            status_we_r      <= status_we_s;
            status_next_r    <= status_next_s;
            current_player_r <= current_player_s;
            turn_timer_r     <= turn_timer_s;
            move_count_r     <= move_count_s;
            game_over_r      <= game_over_s;
            winner_r         <= winner_s;
        end
    end

    // Next-state and next-output logic: everything holds unless an event below changes it.
    always_comb begin
        state_s          = state_r;
        err_cnt_s        = err_cnt_r;
        status_we_s      = 1'b0;
        status_next_s    = status_next_r;
        current_player_s = current_player_r;
        turn_timer_s     = turn_timer_r;
        move_count_s     = move_count_r;
        game_over_s      = game_over_r;
        winner_s         = winner_r;
        move_inc_s       = move_count_r + 6'd1;

        case (state_r)
            // A finished game behaves like an idle one: only start matters.
            IDLE, OVER: begin
                if (start) begin
                    state_s          = TURN;
                    err_cnt_s        = 4'd0;
                    status_we_s      = 1'b1;
                    status_next_s    = CODE_PLAYING;
                    current_player_s = 1'b0;
                    turn_timer_s     = TURN_TIME_C;
                    move_count_s     = 6'd0;
                    game_over_s      = 1'b0;
                    winner_s         = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end

            // Priority within a cycle: legal move, then illegal move, then tick.
            TURN: begin
                if (move_valid) begin
                    move_count_s = move_inc_s;
                    status_we_s  = 1'b1;
                    if (win_detect) begin
                        // The mover keeps the turn so current_player names the winner.
                        status_next_s = win_code(current_player_r);
                        winner_s      = winner_code(current_player_r);
                        game_over_s   = 1'b1;
                        state_s       = OVER;
                    end else if (board_full || (move_inc_s == MAX_MOVES_C)) begin
                        // Entering OVER here is what keeps move_count from passing MAX_MOVES.
                        status_next_s = CODE_DRAW;
                        winner_s      = 2'd3;
                        game_over_s   = 1'b1;
                        state_s       = OVER;
                    end else begin
                        status_next_s    = CODE_PLAYING;
                        current_player_s = ~current_player_r;
                        turn_timer_s     = TURN_TIME_C;
                    end
                end else if (move_invalid) begin
                    status_we_s   = 1'b1;
                    status_next_s = CODE_INVALID;
                    err_cnt_s     = ERR_HOLD_C;
                    state_s       = ERROR;
                end else if (tick) begin
                    if (turn_timer_r == 4'd1) begin
                        // Turn expired: hand over the move and restart the countdown.
                        status_we_s      = 1'b1;
                        status_next_s    = CODE_TIMEOUT;
                        current_player_s = ~current_player_r;
                        turn_timer_s     = TURN_TIME_C;
                    end else if (turn_timer_r > 4'd1) begin
                        turn_timer_s = turn_timer_r - 4'd1;
                    end else begin
                        // A zero timer is never decremented, so it cannot wrap.
                        turn_timer_s = turn_timer_r;
                    end
                end else begin
                    state_s = TURN;
                end
            end

            // Invalid-move status is held for a number of ticks; the turn timer is frozen.
            ERROR: begin
                if (tick) begin
                    if (err_cnt_r <= 4'd1) begin
                        err_cnt_s     = 4'd0;
                        status_we_s   = 1'b1;
                        status_next_s = CODE_PLAYING;
                        turn_timer_s  = TURN_TIME_C;
                        state_s       = TURN;
                    end else begin
                        err_cnt_s = err_cnt_r - 4'd1;
                    end
                end else begin
                    state_s = ERROR;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign status_we      = status_we_r;
    assign status_next    = status_next_r;
    assign current_player = current_player_r;
    assign turn_timer     = turn_timer_r;
    assign move_count     = move_count_r;
    assign game_over      = game_over_r;
    assign winner         = winner_r;

endmodule

// File: tb/tb_game_status_controller.sv
// Bench for game_status_controller.
// Two instances: index 0 with default parameters, index 1 with MAX_MOVES = 4.
// A behavioural model advances alongside the stimulus; each cycle the expected
// output vector of both instances is pushed to a scoreboard queue and popped
// for comparison just after the clock edge.

module tb_game_status_controller;

    localparam int TT = 10;
    localparam int EH = 2;

    logic clk;
    logic rst;
    logic [1:0] start, move_valid, move_invalid, win_detect, board_full, tick;
    logic [1:0] status_we, current_player, game_over;
    logic [1:0][7:0] status_next;
    logic [1:0][3:0] turn_timer;
    logic [1:0][5:0] move_count;
    logic [1:0][1:0] winner;

    int checks;
    int errors;

    // Model state per instance
    int         m_state [2];   // 0 IDLE, 1 TURN, 2 ERROR, 3 OVER
    int         m_max   [2];
    int         m_ec    [2];
    logic       m_we    [2];
    logic [7:0] m_sn    [2];
    logic       m_cp    [2];
    logic [3:0] m_tt    [2];
    logic [5:0] m_mc    [2];
    logic       m_go    [2];
    logic [1:0] m_win   [2];

    logic [22:0] sb_q [$];

    game_status_controller #(.TURN_TIME(TT), .ERR_HOLD(EH), .MAX_MOVES(42)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .move_valid(move_valid[0]),
        .move_invalid(move_invalid[0]), .win_detect(win_detect[0]),
        .board_full(board_full[0]), .tick(tick[0]), .status_we(status_we[0]),
        .status_next(status_next[0]), .current_player(current_player[0]),
        .turn_timer(turn_timer[0]), .move_count(move_count[0]),
        .game_over(game_over[0]), .winner(winner[0])
    );

    game_status_controller #(.TURN_TIME(TT), .ERR_HOLD(EH), .MAX_MOVES(4)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .move_valid(move_valid[1]),
        .move_invalid(move_invalid[1]), .win_detect(win_detect[1]),
        .board_full(board_full[1]), .tick(tick[1]), .status_we(status_we[1]),
        .status_next(status_next[1]), .current_player(current_player[1]),
        .turn_timer(turn_timer[1]), .move_count(move_count[1]),
        .game_over(game_over[1]), .winner(winner[1])
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] obs_vec(input int i);
        return {status_we[i], status_next[i], current_player[i], turn_timer[i],
                move_count[i], game_over[i], winner[i]};
    endfunction

    function automatic logic [22:0] exp_vec(input int i);
        return {m_we[i], m_sn[i], m_cp[i], m_tt[i], m_mc[i], m_go[i], m_win[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_ec[i] = 0; m_we[i] = 1'b0; m_sn[i] = 8'h00;
            m_cp[i] = 1'b0; m_tt[i] = 4'd0; m_mc[i] = 6'd0; m_go[i] = 1'b0;
            m_win[i] = 2'd0;
        end
    endtask

    task automatic model_step(input int i, input logic st, input logic mv, input logic mi,
                              input logic wd, input logic bf, input logic tk);
        m_we[i] = 1'b0;
        if (m_state[i] == 0 || m_state[i] == 3) begin
            if (st) begin
                m_state[i] = 1; m_mc[i] = 6'd0; m_cp[i] = 1'b0; m_tt[i] = 4'(TT);
                m_win[i] = 2'd0; m_go[i] = 1'b0; m_sn[i] = 8'h00; m_we[i] = 1'b1;
            end
        end else if (m_state[i] == 1) begin
            if (mv) begin
                m_mc[i] = m_mc[i] + 6'd1;
                m_we[i] = 1'b1;
                if (wd) begin
                    m_sn[i] = m_cp[i] ? 8'h11 : 8'h10;
                    m_win[i] = m_cp[i] ? 2'd2 : 2'd1;
                    m_go[i] = 1'b1; m_state[i] = 3;
                end else if (bf || int'(m_mc[i]) == m_max[i]) begin
                    m_sn[i] = 8'h20; m_win[i] = 2'd3; m_go[i] = 1'b1; m_state[i] = 3;
                end else begin
                    m_sn[i] = 8'h00; m_cp[i] = ~m_cp[i]; m_tt[i] = 4'(TT);
                end
            end else if (mi) begin
                m_we[i] = 1'b1; m_sn[i] = 8'h01; m_ec[i] = EH; m_state[i] = 2;
            end else if (tk) begin
                if (m_tt[i] == 4'd1) begin
                    m_we[i] = 1'b1; m_sn[i] = 8'h02; m_cp[i] = ~m_cp[i]; m_tt[i] = 4'(TT);
                end else if (m_tt[i] != 4'd0) begin
                    m_tt[i] = m_tt[i] - 4'd1;
                end
            end
        end else if (m_state[i] == 2) begin
            if (tk) begin
                m_ec[i] = m_ec[i] - 1;
                if (m_ec[i] <= 0) begin
                    m_ec[i] = 0; m_we[i] = 1'b1; m_sn[i] = 8'h00;
                    m_tt[i] = 4'(TT); m_state[i] = 1;
                end
            end
        end
    endtask

    // One clock of stimulus on instance `which`; the other instance sees idle inputs.
    task automatic cycle(input int which, input string tag, input logic st, input logic mv,
                         input logic mi, input logic wd, input logic bf, input logic tk);
        logic [22:0] e;
        for (int i = 0; i < 2; i++) begin
            start[i]        = (i == which) ? st : 1'b0;
            move_valid[i]   = (i == which) ? mv : 1'b0;
            move_invalid[i] = (i == which) ? mi : 1'b0;
            win_detect[i]   = (i == which) ? wd : 1'b0;
            board_full[i]   = (i == which) ? bf : 1'b0;
            tick[i]         = (i == which) ? tk : 1'b0;
            model_step(i, start[i], move_valid[i], move_invalid[i], win_detect[i],
                       board_full[i], tick[i]);
            sb_q.push_back(exp_vec(i));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = sb_q.pop_front();
            check_val($sformatf("%s_%s", tag, (i == 0) ? "a" : "b"), {9'd0, obs_vec(i)}, {9'd0, e});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_max[0] = 42;
        m_max[1] = 4;
        start = 2'b00; move_valid = 2'b00; move_invalid = 2'b00;
        win_detect = 2'b00; board_full = 2'b00; tick = 2'b00;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_a", {9'd0, obs_vec(0)}, 32'd0);
        check_val("reset_b", {9'd0, obs_vec(1)}, 32'd0);
        rst = 1'b0;

        // Inputs other than start are ignored in IDLE
        cycle(0, "idle_ign", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        // New game, then one quiet cycle (strobe drops)
        cycle(0, "start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, "quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Three legal moves, then a winning move by player 1
        for (int k = 0; k < 3; k++) cycle(0, "move", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, "win_p1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(0, "over_mv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, "over_tk", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Timeout after TT ticks
        cycle(0, "restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < TT; k++) cycle(0, "tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Invalid move: hold for EH ticks, moves and start ignored, timer frozen
        cycle(0, "tick_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(0, "invalid", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(0, "err_mv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, "err_st", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(0, "err_tk1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(0, "err_tk2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Move and expiring tick in the same cycle: the move wins
        for (int k = 0; k < TT - 1; k++) cycle(0, "run_down", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(0, "mv_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Move beats invalid; start ignored in TURN
        cycle(0, "mv_inv", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(0, "turn_st", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Board full gives a draw
        cycle(0, "full", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(0, "over_st", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Small board: the fourth legal move is a draw, then a new game
        cycle(1, "b_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1, "b_move", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1, "b_over_mv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1, "b_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random play on both instances
        for (int k = 0; k < 600; k++) begin
            logic mv;
            mv = ($urandom_range(0, 3) == 0);
            cycle(k % 2, "rand", ($urandom_range(0, 40) == 0), mv, ($urandom_range(0, 9) == 0),
                  mv && ($urandom_range(0, 14) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        // Asynchronous reset in the middle of a turn
        cycle(0, "pre_rst_st", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, "pre_rst_mv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 2'b00; move_valid = 2'b00; move_invalid = 2'b00;
        win_detect = 2'b00; board_full = 2'b00; tick = 2'b00;
        rst = 1'b1;
        #2;
        model_reset();
        check_val("async_rst_a", {9'd0, obs_vec(0)}, {9'd0, exp_vec(0)});
        check_val("async_rst_b", {9'd0, obs_vec(1)}, {9'd0, exp_vec(1)});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, "post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(0, "post_rst_st", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
